// File: rtl/enc_pkg.sv
// Shared quadrature definitions for the encoder line conditioner and decoder.
package enc_pkg;

    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_10 = 2'b10;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam int FILT_LEN_DEF = 4;

    typedef enum logic {
        PS_WAIT = 1'b0,
        PS_RUN  = 1'b1
    } prime_state_t;

    // Forward rotation on {A,B}: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic logic [1:0] next_fwd(input logic [1:0] state);
        logic [1:0] nxt;
        case (state)
            ST_00:   nxt = ST_01;
            ST_01:   nxt = ST_11;
            ST_11:   nxt = ST_10;
            default: nxt = ST_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/enc_filt_chan.sv
// One encoder line: 2-flop synchroniser, stability filter and a run-length
// tracker used to decide when the line is settled enough to prime on.
module enc_filt_chan
    import enc_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic upd_en,
    input  logic load,
    output logic filt,
    output logic chg,
    output logic glitch,
    output logic stable
);

    localparam int             CW       = 4;
    localparam logic [CW-1:0] TC       = CW'(FILT_LEN - 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(FILT_LEN);

    logic          sync_q1;
    logic          sync_q2;
    logic          sync_prev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hold;
    logic [CW-1:0] hold_nxt;
    logic          diff;

    assign diff   = sync_q2 != filt;
    assign chg    = upd_en && !load && diff && (cnt == TC);
    assign glitch = !load && !diff && (cnt != '0);

    // Length of the current run of identical synchronised samples, saturating.
    always_comb begin
        hold_nxt = hold;
        if (sync_q2 != sync_prev)
            hold_nxt = CW'(1);
        else if (hold != HOLD_MAX)
            hold_nxt = hold + 1'b1;
    end

    assign stable = hold_nxt == HOLD_MAX;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            sync_prev <= 1'b0;
            hold      <= '0;
            cnt       <= '0;
            filt      <= 1'b0;
        end else begin
            sync_q1   <= raw;
            sync_q2   <= sync_q1;
            sync_prev <= sync_q2;
            hold      <= hold_nxt;
            if (load) begin
                filt <= sync_q2;
                cnt  <= '0;
            end else if (!diff) begin
                cnt <= '0;
            end else if (cnt == TC) begin
                // Before priming a qualified change waits here at terminal count.
                if (upd_en) begin
                    filt <= ~filt;
                    cnt  <= '0;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/enc_quad_filter.sv
// Filtered quadrature decoder: priming, direction, position count and error flag.
// Optional rejected-glitch counter output enabled by `define ENC_GLITCH_CNT_EN.
//
// state   | meaning
// PS_WAIT | lines not yet jointly settled; filtered outputs frozen
// PS_RUN  | primed; filtered edges are decoded
module enc_quad_filter
    import enc_pkg::*;
#(
    parameter int FILT_LEN  = FILT_LEN_DEF,
    parameter int POS_WIDTH = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_in,
    input  logic                 b_in,
    input  logic                 set_enc,
    input  logic [POS_WIDTH-1:0] preload,
    input  logic                 err_clr,
    output logic                 a_out,
    output logic                 b_out,
    output logic                 dir,
    output logic                 tick,
    output logic [POS_WIDTH-1:0] count,
    output logic                 err
`ifdef ENC_GLITCH_CNT_EN
    ,
    output logic [15:0]          glitch_cnt
`endif
);

    prime_state_t state_q;
    prime_state_t state_d;
    logic         primed;
    logic         load;
    logic         chg_a, chg_b;
    logic         glitch_a, glitch_b;
    logic         stable_a, stable_b;
    logic [1:0]   ab_cur;
    logic [1:0]   ab_nxt;
    logic         legal;
    logic         illegal;
    logic         fwd;

    enc_filt_chan #(.FILT_LEN(FILT_LEN)) u_chan_a (
        .clk    (clk),
        .reset  (reset),
        .raw    (a_in),
        .upd_en (primed),
        .load   (load),
        .filt   (a_out),
        .chg    (chg_a),
        .glitch (glitch_a),
        .stable (stable_a)
    );

    enc_filt_chan #(.FILT_LEN(FILT_LEN)) u_chan_b (
        .clk    (clk),
        .reset  (reset),
        .raw    (b_in),
        .upd_en (primed),
        .load   (load),
        .filt   (b_out),
        .chg    (chg_b),
        .glitch (glitch_b),
        .stable (stable_b)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= PS_WAIT;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == PS_WAIT && stable_a && stable_b)
            state_d = PS_RUN;
    end

    always_comb begin
        primed = (state_q == PS_RUN);
        load   = (state_q == PS_WAIT) && stable_a && stable_b;
    end

    // Channels only strobe chg once primed, so no extra qualification here.
    assign ab_cur  = {a_out, b_out};
    assign ab_nxt  = ab_cur ^ {chg_a, chg_b};
    assign legal   = chg_a ^ chg_b;
    assign illegal = chg_a & chg_b;
    assign fwd     = ab_nxt == next_fwd(ab_cur);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick  <= 1'b0;
            dir   <= DIR_REV;
            count <= '0;
            err   <= 1'b0;
        end else begin
            tick <= legal;
            if (legal)
                dir <= fwd ? DIR_FWD : DIR_REV;
            if (set_enc)
                count <= preload;
            else if (legal)
                count <= fwd ? count + 1'b1 : count - 1'b1;
            if (illegal)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

`ifdef ENC_GLITCH_CNT_EN
    logic [16:0] glitch_sum;

    assign glitch_sum = {1'b0, glitch_cnt} + {16'b0, glitch_a} + {16'b0, glitch_b};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            glitch_cnt <= '0;
        else if (err_clr)
            glitch_cnt <= '0;
        else if (glitch_sum[16])
            glitch_cnt <= 16'hFFFF;
        else
            glitch_cnt <= glitch_sum[15:0];
    end
`else
    logic unused_glitch;
    assign unused_glitch = glitch_a | glitch_b;
`endif

endmodule

// File: tb/tb_enc_quad_filter.sv
// Scoreboard bench for enc_quad_filter with FILT_LEN=4, POS_WIDTH=25.
module tb_enc_quad_filter;

    localparam int PW = 25;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          a_in    = 1'b0;
    logic          b_in    = 1'b0;
    logic          set_enc = 1'b0;
    logic          err_clr = 1'b0;
    logic [PW-1:0] preload = '0;
    logic          a_out, b_out, dir, tick, err;
    logic [PW-1:0] count;
`ifdef ENC_GLITCH_CNT_EN
    logic [15:0]   glitch_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          dir;
        logic [PW-1:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [1:0] cur_ab = 2'b00;

    always #5 clk = ~clk;

    enc_quad_filter #(.FILT_LEN(4), .POS_WIDTH(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_in       (a_in),
        .b_in       (b_in),
        .set_enc    (set_enc),
        .preload    (preload),
        .err_clr    (err_clr),
        .a_out      (a_out),
        .b_out      (b_out),
        .dir        (dir),
        .tick       (tick),
        .count      (count),
        .err        (err)
`ifdef ENC_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every tick pops one expected {dir,count}; a tick with nothing queued is an error.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("tick_unexp", 32'(tick), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("tick_dir", 32'(dir), 32'(mon_e.dir));
                chk("tick_cnt", 32'(count), 32'(mon_e.cnt));
            end
        end
    end

    task automatic do_reset(input logic a, input logic b);
        reset = 1'b0;
        a_in  = a;
        b_in  = b;
        cyc(2);
        reset = 1'b1;
    endtask

    task automatic step(input logic [1:0] ab, input logic e_dir, input logic [PW-1:0] e_cnt,
                        input bit do_set);
        exp_t e;
        e.dir = e_dir;
        e.cnt = e_cnt;
        exp_q.push_back(e);
        {a_in, b_in} = ab;
        cyc(5);
        chk("step_early", 32'({a_out, b_out}), 32'(cur_ab));
        if (do_set) begin
            set_enc = 1'b1;
            preload = e_cnt;
        end
        cyc(1);
        set_enc = 1'b0;
        chk("step_ab", 32'({a_out, b_out}), 32'(ab));
        chk("step_tick", 32'(tick), 32'd1);
        cur_ab = ab;
        cyc(1);
        chk("tick_width", 32'(tick), 32'd0);
        cyc(13);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1;
        // Priming from 11: 6 clocks after release, no tick/count/err.
        do_reset(1'b1, 1'b1);
        chk("rst_ab", 32'({a_out, b_out}), 32'd0);
        chk("rst_cnt", 32'(count), 32'd0);
        cyc(5);
        chk("prime_early", 32'({a_out, b_out}), 32'd0);
        cyc(1);
        chk("prime_ab", 32'({a_out, b_out}), 32'd3);
        chk("prime_tick", 32'(tick), 32'd0);
        chk("prime_cnt", 32'(count), 32'd0);
        chk("prime_err", 32'(err), 32'd0);

        // Forward then reverse full cycle from 00.
        do_reset(1'b0, 1'b0);
        cyc(10);
        cur_ab = 2'b00;
        chk("p00_ab", 32'({a_out, b_out}), 32'd0);
        step(2'b01, 1'b1, 25'd1, 1'b0);
        step(2'b11, 1'b1, 25'd2, 1'b0);
        step(2'b10, 1'b1, 25'd3, 1'b0);
        step(2'b00, 1'b1, 25'd4, 1'b0);
        chk("fwd_dir", 32'(dir), 32'd1);
        chk("fwd_cnt", 32'(count), 32'd4);
        step(2'b10, 1'b0, 25'd3, 1'b0);
        step(2'b11, 1'b0, 25'd2, 1'b0);
        step(2'b01, 1'b0, 25'd1, 1'b0);
        step(2'b00, 1'b0, 25'd0, 1'b0);
        chk("rev_dir", 32'(dir), 32'd0);
        chk("rev_cnt", 32'(count), 32'd0);

        // 3-sample glitch on A is rejected.
        a_in = 1'b1;
        cyc(3);
        a_in = 1'b0;
        cyc(20);
        chk("glitch_a", 32'(a_out), 32'd0);
        chk("glitch_cnt_pos", 32'(count), 32'd0);
`ifdef ENC_GLITCH_CNT_EN
        chk("glitch_cnt", 32'(glitch_cnt), 32'd1);
`endif

        // Both lines together: illegal.
        a_in = 1'b1;
        b_in = 1'b1;
        cyc(5);
        chk("ill_early", 32'(err), 32'd0);
        cyc(1);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_ab", 32'({a_out, b_out}), 32'd3);
        chk("ill_tick", 32'(tick), 32'd0);
        chk("ill_cnt", 32'(count), 32'd0);
        chk("ill_dir", 32'(dir), 32'd0);
        cur_ab = 2'b11;
        cyc(5);
        chk("err_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 32'd0);
`ifdef ENC_GLITCH_CNT_EN
        chk("glitch_clr", 32'(glitch_cnt), 32'd0);
`endif

        // Reverse wrap below zero, then preload coinciding with a forward edge.
        step(2'b01, 1'b0, 25'h1FFFFFF, 1'b0);
        chk("wrap_cnt", 32'(count), 32'h1FFFFFF);
        step(2'b11, 1'b1, 25'h0000100, 1'b1);
        chk("pre_cnt", 32'(count), 32'h100);
        chk("pre_dir", 32'(dir), 32'd1);

        // Reset in the middle of a qualification.
        a_in = 1'b0;
        cyc(3);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_ab", 32'({a_out, b_out}), 32'd0);
        chk("mid_cnt", 32'(count), 32'd0);
        chk("mid_dir", 32'(dir), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_tick", 32'(tick), 32'd0);
        cyc(1);
        reset = 1'b1;
        cyc(5);
        chk("repr_early", 32'({a_out, b_out}), 32'd0);
        cyc(1);
        chk("repr_ab", 32'({a_out, b_out}), 32'd1);
        chk("repr_tick", 32'(tick), 32'd0);
        chk("repr_cnt", 32'(count), 32'd0);
        cyc(10);
        chk("final_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
